// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data memory initiator.
//   SIZE_*   : encodings of the req_size field
//   state_t  : sub-word store sequencer states
//   merge_lanes : replaces the byte/half lane(s) addressed by a sub-word
//                 store inside the word read back from memory
package mips_mem_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    // Only SIZE_B selects a byte lane; any other size is treated as a half
    // (the caller only invokes this for aligned SB/SH).
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [15:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] w;
        w = old_word;
        if (size == SIZE_B) begin
            case (lane)
                2'd0:    w[7:0]   = wdata[7:0];
                2'd1:    w[15:8]  = wdata[7:0];
                2'd2:    w[23:16] = wdata[7:0];
                default: w[31:24] = wdata[7:0];
            endcase
        end else if (lane[1]) begin
            w[31:16] = wdata;
        end else begin
            w[15:0] = wdata;
        end
        return w;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load aligner: picks the addressed byte/half/word out of the
// memory read word (little-endian lanes) and sign- or zero-extends it.
//   rdata       in  32  word read from memory
//   addr        in  2   low address bits (lane select)
//   size        in  2   SIZE_B / SIZE_H / SIZE_W (reserved -> 0)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   data        out 32  extended load result
module load_extract
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{addr, 3'b000} +: 8];
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_B:  data = is_unsigned ? {24'h0, byte_lane}
                                        : {{24{byte_lane[7]}}, byte_lane};
            SIZE_H:  data = is_unsigned ? {16'h0, half_lane}
                                        : {{16{half_lane[15]}}, half_lane};
            SIZE_W:  data = rdata;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-wide data memory (byte address, async read,
// word write). Loads and SW complete in one cycle; SB/SH run as a two-cycle
// read-modify-write (read + merge in IDLE, write in MERGE).
//   clk, rst           clock, synchronous active-high reset
//   req_valid/we/size/unsigned/addr/wdata   pipeline memory request
//   load_data          aligned, extended load result (combinational)
//   stall_o            freeze IF/ID/EX/MEM this cycle
//   err_o              misaligned / out-of-range / reserved-size request
//   err_cnt            saturating count of error requests
//   mem_we/addr/wdata  memory write port, mem_rdata async read data
//   fsm_state          current sequencer state (debug observation)
//
// Handshake: req_valid marks a request; stall_o is the inverse of "ready".
// A request with stall_o=1 is not complete and the pipeline must hold the
// same req_* values into the next cycle, where it completes with stall_o=0.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic [WIDTH-1:0] load_data,
    output logic             stall_o,
    output logic             err_o,
    output logic [7:0]       err_cnt,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output state_t           fsm_state
);

    state_t           st_q, st_d;
    logic [WIDTH-1:0] addr_q, merge_q;
    logic [WIDTH-1:0] extracted;
    logic             bad;
    logic             capture;

    load_extract u_load_extract (
        .rdata       (mem_rdata),
        .addr        (req_addr[1:0]),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .data        (extracted)
    );

    // Request decode: independent of req_valid, qualified below.
    always_comb begin
        case (req_size)
            SIZE_H:   bad = req_addr[0];
            SIZE_W:   bad = (req_addr[1:0] != 2'b00);
            SIZE_RSV: bad = 1'b1;
            default:  bad = 1'b0;
        endcase
        if (req_addr >= WIDTH'(MEM_BYTES)) bad = 1'b1;
    end

    always_comb begin
        st_d      = st_q;
        mem_we    = 1'b0;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        load_data = '0;
        stall_o   = 1'b0;
        err_o     = 1'b0;
        capture   = 1'b0;
        case (st_q)
            IDLE: begin
                if (req_valid) begin
                    if (bad) begin
                        err_o = 1'b1;
                    end else if (!req_we) begin
                        load_data = extracted;
                    end else if (req_size == SIZE_W) begin
                        mem_we = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        capture = 1'b1;
                        st_d    = MERGE;
                    end
                end
            end
            MERGE: begin
                // The held store on req_* is ignored; the merged word was
                // captured in the previous cycle.
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merge_q;
                st_d      = IDLE;
            end
            default: st_d = IDLE;
        endcase
        // Reset must also suppress a pending MERGE write this very cycle.
        if (rst) begin
            mem_we  = 1'b0;
            stall_o = 1'b0;
            st_d    = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= IDLE;
            addr_q  <= '0;
            merge_q <= '0;
            err_cnt <= 8'h00;
        end else begin
            st_q <= st_d;
            if (capture) begin
                addr_q  <= req_addr;
                merge_q <= merge_lanes(mem_rdata, req_wdata[15:0], req_size,
                                       req_addr[1:0]);
            end
            if (err_o && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'h01;
        end
    end

    assign fsm_state = st_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
    logic        stall_o, err_o, mem_we;
    logic [7:0]  err_cnt;
    state_t      fsm_state;

    always #5 clk = ~clk;

    mem_access_unit #(.WIDTH(32), .MEM_BYTES(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .load_data    (load_data),
        .stall_o      (stall_o),
        .err_o        (err_o),
        .err_cnt      (err_cnt),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .fsm_state    (fsm_state)
    );

    // Word memory attached to the DUT port: async read, write on clk.
    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we && mem_addr < 32'd1024) mem[mem_addr[9:2]] <= mem_wdata;
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        valid, we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, wdata;
        logic        e_stall, e_we, e_err;
        logic [31:0] e_load, e_wdata;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic we, logic [1:0] sz, logic uns,
                                logic [31:0] a, logic [31:0] wd, logic es, logic ew,
                                logic ee, logic [31:0] el, logic [31:0] ewd, logic [7:0] ec);
        vec_t t;
        t.valid = v; t.we = we; t.size = sz; t.uns = uns; t.addr = a; t.wdata = wd;
        t.e_stall = es; t.e_we = ew; t.e_err = ee; t.e_load = el; t.e_wdata = ewd;
        t.e_cnt = ec;
        return t;
    endfunction

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:1023];
    int         ref_cnt;

    function automatic logic [31:0] ref_word(int base);
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    function automatic logic ref_err(logic [1:0] sz, logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (a >= 32'd1024) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(logic [1:0] sz, logic uns, int a);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = 32'(ref_mem[a]);
            if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = 32'(ref_mem[a]) + 32'(ref_mem[a+1]) * 32'd256;
            if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = ref_word(a);
        end
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        vec_t v;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset with a sub-word store presented: nothing may leak out.
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_B; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'hFF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_cnt", 32'(err_cnt), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'(IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;

        //          v  we size   u  addr        wdata        stl we err load          ewdata       cnt
        vecs.push_back(mk(1, 1, SIZE_W, 0, 32'h10,  32'hDEADBEEF, 0, 1, 0, 32'h0,         32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 0, SIZE_W, 0, 32'h10,  32'h0,        0, 0, 0, 32'hDEADBEEF,  32'h0,        0));
        vecs.push_back(mk(1, 1, SIZE_B, 0, 32'h11,  32'h000000AA, 1, 0, 0, 32'h0,         32'h0,        0));
        vecs.push_back(mk(1, 1, SIZE_B, 0, 32'h11,  32'h000000AA, 0, 1, 0, 32'h0,         32'hDEADAAEF, 0));
        vecs.push_back(mk(1, 0, SIZE_B, 1, 32'h11,  32'h0,        0, 0, 0, 32'h000000AA,  32'h0,        0));
        vecs.push_back(mk(1, 0, SIZE_B, 0, 32'h11,  32'h0,        0, 0, 0, 32'hFFFFFFAA,  32'h0,        0));
        vecs.push_back(mk(1, 1, SIZE_H, 0, 32'h12,  32'h00001234, 1, 0, 0, 32'h0,         32'h0,        0));
        vecs.push_back(mk(1, 1, SIZE_H, 0, 32'h12,  32'h00001234, 0, 1, 0, 32'h0,         32'h1234AAEF, 0));
        vecs.push_back(mk(1, 0, SIZE_H, 0, 32'h12,  32'h0,        0, 0, 0, 32'h00001234,  32'h0,        0));
        vecs.push_back(mk(1, 0, SIZE_H, 0, 32'h10,  32'h0,        0, 0, 0, 32'hFFFFAAEF,  32'h0,        0));
        vecs.push_back(mk(1, 0, SIZE_H, 1, 32'h10,  32'h0,        0, 0, 0, 32'h0000AAEF,  32'h0,        0));
        vecs.push_back(mk(1, 0, SIZE_W, 0, 32'h13,  32'h0,        0, 0, 1, 32'h0,         32'h0,        0));
        vecs.push_back(mk(1, 1, SIZE_H, 0, 32'h11,  32'h5555,     0, 0, 1, 32'h0,         32'h0,        1));
        vecs.push_back(mk(1, 1, SIZE_W, 0, 32'h400, 32'h12345678, 0, 0, 1, 32'h0,         32'h0,        2));
        vecs.push_back(mk(1, 0, SIZE_RSV,0, 32'h0,  32'h0,        0, 0, 1, 32'h0,         32'h0,        3));
        vecs.push_back(mk(1, 0, SIZE_B, 0, 32'h3FF, 32'h0,        0, 0, 0, 32'h0,         32'h0,        4));
        vecs.push_back(mk(0, 0, SIZE_W, 0, 32'h44,  32'h77,       0, 0, 0, 32'h0,         32'h0,        4));
        vecs.push_back(mk(1, 1, SIZE_W, 0, 32'h3FC, 32'h80000000, 0, 1, 0, 32'h0,         32'h80000000, 4));
        vecs.push_back(mk(1, 0, SIZE_B, 0, 32'h3FF, 32'h0,        0, 0, 0, 32'hFFFFFF80,  32'h0,        4));
        vecs.push_back(mk(1, 0, SIZE_B, 1, 32'h3FF, 32'h0,        0, 0, 0, 32'h00000080,  32'h0,        4));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.valid, v.we, v.size, v.uns, v.addr, v.wdata);
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(v.e_stall));
            chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'(v.e_we));
            chk($sformatf("vec%0d_err", i), 32'(err_o), 32'(v.e_err));
            chk($sformatf("vec%0d_load", i), load_data, v.e_load);
            chk($sformatf("vec%0d_cnt", i), 32'(err_cnt), 32'(v.e_cnt));
            chk($sformatf("vec%0d_addr", i), mem_addr, v.addr);
            if (v.e_we) chk($sformatf("vec%0d_wdata", i), mem_wdata, v.e_wdata);
        end

        // Reset during MERGE aborts the write.
        mem[8] = 32'h55667788;
        drive(1, 1, SIZE_B, 0, 32'h20, 32'h99);
        @(negedge clk);
        chk("rstm_stall1", 32'(stall_o), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstm_we", 32'(mem_we), 32'd0);
        chk("rstm_stall2", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstm_state", 32'(fsm_state), 32'(IDLE));
        chk("rstm_cnt", 32'(err_cnt), 32'd0);
        chk("rstm_word", mem[8], 32'h55667788);

        // Back-to-back sub-word stores into a zeroed word.
        mem[9] = 32'h0;
        drive(1, 1, SIZE_B, 0, 32'h24, 32'h11);
        @(negedge clk); chk("b2b_stall1", 32'(stall_o), 32'd1);
        drive(1, 1, SIZE_B, 0, 32'h24, 32'h11);
        @(negedge clk); chk("b2b_stall2", 32'(stall_o), 32'd0);
        chk("b2b_wd1", mem_wdata, 32'h00000011);
        drive(1, 1, SIZE_B, 0, 32'h25, 32'h22);
        @(negedge clk); chk("b2b_stall3", 32'(stall_o), 32'd1);
        drive(1, 1, SIZE_B, 0, 32'h25, 32'h22);
        @(negedge clk); chk("b2b_stall4", 32'(stall_o), 32'd0);
        chk("b2b_wd2", mem_wdata, 32'h00002211);
        drive(0, 0, SIZE_W, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("b2b_word", mem[9], 32'h00002211);

        // Randomized phase against the byte-array reference model.
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
        ref_cnt = 0;
        for (int n = 0; n < 1500; n++) begin
            logic        rv, rwe, runs, e;
            logic [1:0]  rsz;
            logic [31:0] ra, rwd;
            int          sel;
            rv   = ($urandom_range(0, 9) != 0);
            rwe  = 1'($urandom_range(0, 1));
            runs = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 15);
            rsz  = (sel == 15) ? 2'd3 : 2'(sel % 3);
            rwd  = $urandom;
            if ($urandom_range(0, 7) != 0) ra = 32'($urandom_range(0, 1023));
            else if ($urandom_range(0, 1) != 0) ra = 32'($urandom_range(1024, 2047));
            else ra = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rsz == 2'd1) ra = ra - (ra % 2);
                if (rsz == 2'd2) ra = ra - (ra % 4);
            end
            e = rv && ref_err(rsz, ra);

            drive(rv, rwe, rsz, runs, ra, rwd);
            @(negedge clk);
            chk("rnd_cnt", 32'(err_cnt), 32'(ref_cnt));
            chk("rnd_err", 32'(err_o), 32'(e));
            chk("rnd_addr", mem_addr, ra);
            if (!rv || e) begin
                chk("rnd_idle_we", 32'(mem_we), 32'd0);
                chk("rnd_idle_stall", 32'(stall_o), 32'd0);
                chk("rnd_idle_load", load_data, 32'h0);
                if (e && ref_cnt < 255) ref_cnt++;
            end else if (!rwe) begin
                chk("rnd_load", load_data, ref_load(rsz, runs, int'(ra)));
                chk("rnd_load_we", 32'(mem_we), 32'd0);
            end else if (rsz == 2'd2) begin
                chk("rnd_sw_we", 32'(mem_we), 32'd1);
                chk("rnd_sw_stall", 32'(stall_o), 32'd0);
                chk("rnd_sw_wdata", mem_wdata, rwd);
                for (int k = 0; k < 4; k++) ref_mem[int'(ra) + k] = 8'(rwd >> (8 * k));
            end else begin
                chk("rnd_rmw_stall1", 32'(stall_o), 32'd1);
                chk("rnd_rmw_we1", 32'(mem_we), 32'd0);
                ref_mem[int'(ra)] = rwd[7:0];
                if (rsz == 2'd1) ref_mem[int'(ra) + 1] = rwd[15:8];
                drive(rv, rwe, rsz, runs, ra, rwd);
                @(negedge clk);
                chk("rnd_rmw_stall2", 32'(stall_o), 32'd0);
                chk("rnd_rmw_we2", 32'(mem_we), 32'd1);
                chk("rnd_rmw_addr2", mem_addr, ra);
                chk("rnd_rmw_wdata", mem_wdata, ref_word(int'(ra) - int'(ra % 4)));
                chk("rnd_rmw_cnt", 32'(err_cnt), 32'(ref_cnt));
            end
        end
        drive(0, 0, SIZE_W, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("final_cnt", 32'(err_cnt), 32'(ref_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
